// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared core sizes, fetch state encoding and fetch queue entry type
package segre_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_SIZE-1:0] word_align(input logic [ADDR_SIZE-1:0] addr);
    return addr & {{(ADDR_SIZE-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/segre_fifo.sv
// rtl/segre_fifo.sv - circular-buffer queue with flush; pointers carry one extra wrap bit
module segre_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                   clk,
  input  logic                   rsn,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t      mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/segre_if_fetch_unit.sv
// rtl/segre_if_fetch_unit.sv - instruction fetch front end: PC, one-outstanding I-cache FSM, fetch queue
module segre_if_fetch_unit
  import segre_pkg::*;
#(
  parameter int                   FETCH_DEPTH = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  output logic                         ic_req_valid_o,
  input  logic                         ic_req_ready_i,
  output logic [ADDR_SIZE-1:0]         ic_req_addr_o,
  input  logic                         ic_rsp_valid_i,
  input  logic [WORD_SIZE-1:0]         ic_rsp_instr_i,
  input  logic                         redirect_i,
  input  logic [ADDR_SIZE-1:0]         redirect_pc_i,
  output logic                         dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [WORD_SIZE-1:0]         dec_instr_o,
  output logic [ADDR_SIZE-1:0]         dec_pc_o,
  output logic [$clog2(FETCH_DEPTH):0] fq_count_o
);

  localparam int CW = $clog2(FETCH_DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d, req_pc_q;
  logic                 drop_q, drop_d;
  logic                 room, push, pop, fq_empty, fq_full;
  fetch_entry_t         push_entry, head;

  // The in-flight request already owns a queue slot, so it is counted against capacity.
  assign room = ({1'b0, fq_count_o} + (CW+1)'(state_q == FETCH_WAIT)) < (CW+1)'(FETCH_DEPTH);

  assign ic_req_valid_o = (state_q == FETCH_REQ) && !redirect_i;
  assign ic_req_addr_o  = pc_q;
  assign push = (state_q == FETCH_WAIT) && ic_rsp_valid_i && !drop_q && !redirect_i && !fq_full;
  assign pop  = dec_valid_o && dec_ready_i;
  assign push_entry = '{pc: req_pc_q, instr: ic_rsp_instr_i};

  assign dec_valid_o = !fq_empty && !redirect_i;
  assign dec_instr_o = fq_empty ? NOP_INSTR : head.instr;
  assign dec_pc_o    = fq_empty ? '0 : head.pc;

  segre_fifo #(
    .DEPTH   (FETCH_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fetch_queue (
    .clk       (clk_i),
    .rsn       (rsn_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count_o)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
      // An outstanding response not yet returned must be swallowed when it arrives.
      if (state_q == FETCH_WAIT && !ic_rsp_valid_i) begin
        drop_d = 1'b1;
      end else begin
        state_d = FETCH_IDLE;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH_IDLE: if (room) state_d = FETCH_REQ;
        FETCH_REQ: begin
          if (ic_req_ready_i) begin
            state_d = FETCH_WAIT;
            pc_d    = pc_q + ADDR_SIZE'(4);
          end
        end
        FETCH_WAIT: begin
          if (ic_rsp_valid_i) begin
            drop_d  = 1'b0;
            state_d = room ? FETCH_REQ : FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (ic_req_valid_o && ic_req_ready_i) req_pc_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_segre_if_fetch_unit.sv
// tb/tb_segre_if_fetch_unit.sv - randomized bench for segre_if_fetch_unit against a queue-level model
module tb_segre_if_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rsn_i = 1'b0;
  logic        ic_req_valid_o;
  logic        ic_req_ready_i = 1'b0;
  logic [31:0] ic_req_addr_o;
  logic        ic_rsp_valid_i = 1'b0;
  logic [31:0] ic_rsp_instr_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [2:0]  fq_count_o;

  always #5 clk = ~clk;

  segre_if_fetch_unit #(
    .FETCH_DEPTH (DEPTH),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_i          (clk),
    .rsn_i          (rsn_i),
    .ic_req_valid_o (ic_req_valid_o),
    .ic_req_ready_i (ic_req_ready_i),
    .ic_req_addr_o  (ic_req_addr_o),
    .ic_rsp_valid_i (ic_rsp_valid_i),
    .ic_rsp_instr_i (ic_rsp_instr_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .dec_valid_o    (dec_valid_o),
    .dec_ready_i    (dec_ready_i),
    .dec_instr_o    (dec_instr_o),
    .dec_pc_o       (dec_pc_o),
    .fq_count_o     (fq_count_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: fetched-but-undecoded instructions, the fetch PC, and whether a request is
  // being offered, is in flight, or is in flight but no longer wanted.
  ent_t        mq[$];
  bit          m_issuing, m_out, m_stale;
  logic [31:0] m_pc, m_req_pc;

  int          n_checks = 0, n_fail = 0;
  int          p_ready = 100, p_dec = 100, p_redir = 0, dly_min = 1, dly_max = 1;
  bit          force_redir = 1'b0, reset_mid = 1'b0;
  logic [31:0] redir_target = '0;
  int          rsp_timer = 0;
  logic [31:0] rsp_data = '0;
  int          cyc = 0, first_req = -1, first_dec = -1, stall_hits = 0;
  logic [31:0] acc_addrs[$];
  logic [31:0] pops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] nth(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_issuing = 1'b0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_pc      = 32'h0;
    m_req_pc  = 32'h0;
  endfunction

  function automatic void model_update();
    int   qb;
    bit   ob;
    ent_t e;
    qb = mq.size();
    ob = m_out;
    if (redirect_i) begin
      mq.delete();
      if (m_out) begin
        if (ic_rsp_valid_i) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
      m_issuing = 1'b0;
      m_pc      = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if (qb > 0 && dec_ready_i) void'(mq.pop_front());
      if (m_out && ic_rsp_valid_i) begin
        if (!m_stale) begin
          e.pc    = m_req_pc;
          e.instr = ic_rsp_instr_i;
          mq.push_back(e);
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (m_issuing && ic_req_ready_i) begin
        m_out     = 1'b1;
        m_req_pc  = m_pc;
        m_pc      = m_pc + 32'd4;
        m_issuing = 1'b0;
      end
      // Queued plus in-flight instructions may never exceed the queue capacity.
      if (!m_issuing && !m_out && (qb + int'(ob)) < DEPTH) m_issuing = 1'b1;
    end
  endfunction

  task automatic compare();
    bit ev, dv;
    ev = m_issuing && !redirect_i;
    dv = (mq.size() != 0) && !redirect_i;
    chk("req_valid", 32'(ic_req_valid_o), 32'(ev));
    if (ev) chk("req_addr", ic_req_addr_o, m_pc);
    chk("addr_lsb", 32'(ic_req_addr_o[1:0]), 32'h0);
    chk("dec_valid", 32'(dec_valid_o), 32'(dv));
    chk("dec_pc", dec_pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("dec_instr", dec_instr_o, (mq.size() != 0) ? mq[0].instr : NOP);
    chk("fq_count", 32'(fq_count_o), 32'(mq.size()));
  endtask

  task automatic observe();
    if (ic_req_valid_o && first_req < 0) first_req = cyc;
    if (dec_valid_o && first_dec < 0) first_dec = cyc;
    if (ic_req_valid_o && !ic_req_ready_i && ic_req_addr_o == 32'hFFFF_FFFC) stall_hits++;
    if (ic_req_valid_o && ic_req_ready_i) begin
      acc_addrs.push_back(ic_req_addr_o);
      rsp_timer = $urandom_range(dly_max, dly_min);
      rsp_data  = $urandom;
    end
    if (dec_valid_o && dec_ready_i) pops.push_back(dec_pc_o);
  endtask

  task automatic step();
    ic_rsp_valid_i = 1'b0;
    ic_rsp_instr_i = $urandom;
    if (rsp_timer == 1) begin
      ic_rsp_valid_i = 1'b1;
      ic_rsp_instr_i = rsp_data;
      rsp_timer      = 0;
    end else if (rsp_timer > 1) begin
      rsp_timer = rsp_timer - 1;
    end
    ic_req_ready_i = int'($urandom_range(0, 99)) < p_ready;
    dec_ready_i    = int'($urandom_range(0, 99)) < p_dec;
    redirect_i     = force_redir || (int'($urandom_range(0, 99)) < p_redir);
    redirect_pc_i  = force_redir ? redir_target : $urandom;
    #1;
    if (!rsn_i) model_reset();
    compare();
    observe();
    if (reset_mid) begin
      #2 rsn_i = 1'b0;
      #1;
      chk("rst_req_valid", 32'(ic_req_valid_o), 32'h0);
      chk("rst_dec_valid", 32'(dec_valid_o), 32'h0);
      chk("rst_fq_count", 32'(fq_count_o), 32'h0);
      chk("rst_dec_pc", dec_pc_o, 32'h0);
      chk("rst_dec_instr", dec_instr_o, NOP);
      model_reset();
      reset_mid = 1'b0;
    end else if (rsn_i) begin
      model_update();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_obs();
    acc_addrs.delete();
    pops.delete();
    cyc        = 0;
    first_req  = -1;
    first_dec  = -1;
    stall_hits = 0;
  endtask

  task automatic do_reset();
    rsn_i       = 1'b0;
    force_redir = 1'b0;
    p_redir     = 0;
    rsp_timer   = 0;
    step();
    step();
    rsn_i = 1'b1;
    start_obs();
  endtask

  initial begin
    @(negedge clk);

    // Streaming with a 1-cycle cache and an always-ready decoder.
    do_reset();
    p_ready = 100; p_dec = 100; dly_min = 1; dly_max = 1;
    repeat (12) step();
    chk("A_first_req_cycle", 32'(first_req), 32'd1);
    chk("A_first_dec_cycle", 32'(first_dec), 32'd3);
    chk("A_pop0", nth(pops, 0), 32'h0);
    chk("A_pop1", nth(pops, 1), 32'h4);
    chk("A_pop2", nth(pops, 2), 32'h8);

    // Decode stalled: queue fills to capacity and fetch stops.
    do_reset();
    p_dec = 0;
    repeat (16) step();
    chk("B_req_count", 32'(acc_addrs.size()), 32'd4);
    chk("B_fq_full", 32'(fq_count_o), 32'd4);
    chk("B_req_idle", 32'(ic_req_valid_o), 32'h0);
    p_dec = 100;
    repeat (12) step();
    chk("B_drain0", nth(pops, 0), 32'h0);
    chk("B_drain3", nth(pops, 3), 32'hC);
    chk("B_resume", nth(acc_addrs, 4), 32'h10);

    // Redirect while waiting; the stale response lands one cycle later.
    do_reset();
    dly_min = 2; dly_max = 2;
    step(); step();
    force_redir = 1'b1; redir_target = 32'h0000_0102;
    step();
    force_redir = 1'b0;
    chk("C_flushed", 32'(fq_count_o), 32'h0);
    repeat (8) step();
    chk("C_req0", nth(acc_addrs, 0), 32'h0);
    chk("C_req1", nth(acc_addrs, 1), 32'h100);
    chk("C_pop0", nth(pops, 0), 32'h100);

    // Redirect coinciding with a response and a ready decoder on a non-empty queue.
    do_reset();
    dly_min = 1; dly_max = 1; p_dec = 0;
    repeat (4) step();
    force_redir = 1'b1; redir_target = 32'h0000_0200; p_dec = 100;
    step();
    force_redir = 1'b0;
    chk("D_no_pop", 32'(pops.size()), 32'h0);
    chk("D_flushed", 32'(fq_count_o), 32'h0);
    repeat (8) step();
    chk("D_req2", nth(acc_addrs, 2), 32'h200);
    chk("D_pop0", nth(pops, 0), 32'h200);

    // Cache back-pressure at the top of the address space, then wrap.
    do_reset();
    p_ready = 0;
    force_redir = 1'b1; redir_target = 32'hFFFF_FFFE;
    step();
    force_redir = 1'b0;
    repeat (6) step();
    p_ready = 100;
    repeat (6) step();
    chk("E_stall_cycles", 32'(stall_hits), 32'd5);
    chk("E_req0", nth(acc_addrs, 0), 32'hFFFF_FFFC);
    chk("E_req1_wrap", nth(acc_addrs, 1), 32'h0);

    // Reset while a response is outstanding; it returns after reset is released.
    do_reset();
    dly_min = 3; dly_max = 3;
    step(); step();
    reset_mid = 1'b1;
    step();
    step();
    rsn_i = 1'b1;
    start_obs();
    repeat (10) step();
    chk("F_restart_addr", nth(acc_addrs, 0), 32'h0);
    chk("F_first_req_cycle", 32'(first_req), 32'd1);
    chk("F_pop0", nth(pops, 0), 32'h0);

    // Randomized traffic.
    do_reset();
    p_ready = 60; p_dec = 60; p_redir = 5; dly_min = 1; dly_max = 3;
    repeat (3000) step();
    p_dec = 20; p_redir = 2;
    repeat (1500) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
